cpu_control: RTL and testbench

Multi-cycle control unit for the 8-bit CPU, and the driving side of the ALU interface. It fetches 16-bit instructions from a synchronous program ROM, decodes them, and reads data memory for memory operands. It then drives operands, carry-in and `Operation` to the ALU, registers the result into the accumulator and flags, and sequences stores, conditional jumps and halt.

---
 rtl/cpu_pkg.sv | 11 +
 rtl/cpu_control_if.sv | 36 +++
 rtl/cpu_control.sv | 125 ++++++++++++
 tb/tb_cpu_control.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types: the ALU operation encoding seen on the control/ALU boundary.
package cpu_pkg;
   typedef enum logic [2:0] {
      OP_ADD  = 3'd0,
      OP_SUB  = 3'd1,
      OP_NOR  = 3'd2,
      OP_NAND = 3'd3,
      OP_XOR  = 3'd4,
      OP_XNOR = 3'd5
   } Operation;
endpackage

// File: rtl/cpu_control_if.sv
// Bus bundle of the control unit: enable, program ROM, data memory, ALU and status.
interface cpu_control_if;
   logic                _iEnable;
   logic [7:0]          _oPAddr;
   logic [15:0]         _iPData;
   logic [7:0]          _oDAddr;
   logic                _oDRead;
   logic [7:0]          _iDData;
   logic                _oDWrite;
   logic [7:0]          _oDData;
   logic [7:0]          _oAluA;
   logic [7:0]          _oAluB;
   logic                _oAluC;
   cpu_pkg::Operation   _oAluOp;
   logic [7:0]          _iAluResult;
   logic                _iAluCarry;
   logic                _iAluZero;
   logic                _iAluNeg;
   logic [7:0]          _oAcc;
   logic                _oFlagC;
   logic                _oFlagZ;
   logic                _oFlagN;
   logic                _oHalted;

   modport master (
      input  _iEnable, _iPData, _iDData, _iAluResult, _iAluCarry, _iAluZero, _iAluNeg,
      output _oPAddr, _oDAddr, _oDRead, _oDWrite, _oDData, _oAluA, _oAluB, _oAluC,
             _oAluOp, _oAcc, _oFlagC, _oFlagZ, _oFlagN, _oHalted
   );

   modport slave (
      output _iEnable, _iPData, _iDData, _iAluResult, _iAluCarry, _iAluZero, _iAluNeg,
      input  _oPAddr, _oDAddr, _oDRead, _oDWrite, _oDData, _oAluA, _oAluB, _oAluC,
             _oAluOp, _oAcc, _oFlagC, _oFlagZ, _oFlagN, _oHalted
   );
endinterface

// File: rtl/cpu_control.sv
// Multi-cycle FETCH/DECODE/EXECUTE control unit for the 8-bit CPU; drives the ALU
// and owns PC, IR, accumulator and flags.
module cpu_control
   import cpu_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   cpu_control_if.master bus
);
   typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;

   state_t      state_q, state_d;
   logic [7:0]  pc_q, pc_d, acc_q, acc_d;
   logic [15:0] ir_q, ir_d;
   logic        c_q, c_d, z_q, z_d, n_q, n_d;
   logic [3:0]  opc_ir, opc_rom;
   logic [7:0]  operand, d_addr;
   logic        d_read, d_write, alu_c, taken, en;
   Operation    alu_op;

   // Instructions whose operand may come from data memory (LDA and the ALU ops).
   function automatic logic mem_operand(input logic [3:0] opc, input logic imm);
      return !imm && (opc == 4'h1 || (opc >= 4'h3 && opc <= 4'hA));
   endfunction

   assign en      = bus._iEnable;
   assign opc_ir  = ir_q[15:12];
   assign opc_rom = bus._iPData[15:12];
   assign operand = ir_q[8] ? ir_q[7:0] : bus._iDData;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      acc_d   = acc_q;
      c_d     = c_q;
      z_d     = z_q;
      n_d     = n_q;
      d_addr  = ir_q[7:0];
      d_read  = 1'b0;
      d_write = 1'b0;
      alu_op  = OP_ADD;
      alu_c   = 1'b0;
      taken   = 1'b0;
      case (state_q)
         S_FETCH: if (en) state_d = S_DECODE;
         S_DECODE: begin
            d_addr = bus._iPData[7:0];
            d_read = mem_operand(opc_rom, bus._iPData[8]);
            if (en) begin
               ir_d    = bus._iPData;
               state_d = (opc_rom == 4'hF) ? S_HALT : S_EXEC;
            end
         end
         S_EXEC: begin
            d_read  = mem_operand(opc_ir, ir_q[8]);
            d_write = en && (opc_ir == 4'h2);
            case (opc_ir)
               4'h4:    alu_op = OP_SUB;
               4'h5:    alu_c  = c_q;
               4'h6:    begin alu_op = OP_SUB; alu_c = c_q; end
               4'h7:    alu_op = OP_NOR;
               4'h8:    alu_op = OP_NAND;
               4'h9:    alu_op = OP_XOR;
               4'hA:    alu_op = OP_XNOR;
               4'hB:    taken  = 1'b1;
               4'hC:    taken  = z_q;
               4'hD:    taken  = c_q;
               4'hE:    taken  = n_q;
               default: ;
            endcase
            if (en) begin
               state_d = S_FETCH;
               pc_d    = taken ? ir_q[7:0] : pc_q + 8'd1;
               if (opc_ir == 4'h1) begin
                  acc_d = operand;
                  z_d   = (operand == 8'd0);
                  n_d   = operand[7];
               end else if (opc_ir >= 4'h3 && opc_ir <= 4'hA) begin
                  acc_d = bus._iAluResult;
                  c_d   = bus._iAluCarry;
                  z_d   = bus._iAluZero;
                  n_d   = bus._iAluNeg;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_FETCH;
         pc_q    <= 8'd0;
         ir_q    <= 16'd0;
         acc_q   <= 8'd0;
         c_q     <= 1'b0;
         z_q     <= 1'b0;
         n_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         acc_q   <= acc_d;
         c_q     <= c_d;
         z_q     <= z_d;
         n_q     <= n_d;
      end
   end

   assign bus._oPAddr  = pc_q;
   assign bus._oDAddr  = d_addr;
   assign bus._oDRead  = d_read;
   assign bus._oDWrite = d_write;
   assign bus._oDData  = acc_q;
   assign bus._oAluA   = acc_q;
   assign bus._oAluB   = operand;
   assign bus._oAluC   = alu_c;
   assign bus._oAluOp  = alu_op;
   assign bus._oAcc    = acc_q;
   assign bus._oFlagC  = c_q;
   assign bus._oFlagZ  = z_q;
   assign bus._oFlagN  = n_q;
   assign bus._oHalted = (state_q == S_HALT);
endmodule

// File: tb/tb_cpu_control.sv
// Bench for cpu_control: ROM/RAM/ALU stand-ins, a directed program table, hand
// sequences for stall/reset/halt, and random programs checked by an ISA-level model.
module tb_cpu_control;
   import cpu_pkg::*;

   logic clk = 1'b0;
   logic reset;
   cpu_control_if dif ();

   cpu_control dut (.clk(clk), .reset(reset), .bus(dif));

   always #5 clk = ~clk;

   logic [15:0] rom [256];
   logic [7:0]  mem [256];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          wr_cnt = 0;
   logic [7:0]  wr_addr_last = 8'h00;

   // ALU stand-in: SUB is A - B - Cin with carry meaning borrow; logic ops clear carry.
   function automatic logic [8:0] alu_f(input Operation op, input logic [7:0] a, b, input logic cin);
      logic [8:0] r;
      case (op)
         OP_ADD:  r = {1'b0, a} + {1'b0, b} + {8'd0, cin};
         OP_SUB:  r = {1'b0, a} - {1'b0, b} - {8'd0, cin};
         OP_NOR:  r = {1'b0, ~(a | b)};
         OP_NAND: r = {1'b0, ~(a & b)};
         OP_XOR:  r = {1'b0, a ^ b};
         default: r = {1'b0, ~(a ^ b)};
      endcase
      return r;
   endfunction

   logic [8:0] alu_r;
   assign alu_r           = alu_f(dif._oAluOp, dif._oAluA, dif._oAluB, dif._oAluC);
   assign dif._iAluResult = alu_r[7:0];
   assign dif._iAluCarry  = alu_r[8];
   assign dif._iAluZero   = (alu_r[7:0] == 8'd0);
   assign dif._iAluNeg    = alu_r[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock: sample bus requests mid-cycle, then model sync ROM/RAM just after the edge.
   task automatic tick();
      logic [7:0] pa, da, dd;
      logic       rd, wr;
      @(negedge clk);
      pa = dif._oPAddr; da = dif._oDAddr; dd = dif._oDData;
      rd = dif._oDRead; wr = dif._oDWrite;
      @(posedge clk);
      #1;
      dif._iPData = rom[pa];
      if (rd === 1'b1) dif._iDData = mem[da];
      if (wr === 1'b1) begin
         mem[da] = dd;
         wr_cnt++;
         wr_addr_last = da;
      end
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      wr_cnt = 0;
   endtask

   function automatic logic exp_rd(input logic [15:0] ins);
      return !ins[8] && (ins[15:12] == 4'h1 || (ins[15:12] >= 4'h3 && ins[15:12] <= 4'hA));
   endfunction

   typedef struct {
      logic [7:0]  addr;
      logic [15:0] instr;
      logic [7:0]  acc;
      logic        c, z, n;
      logic [7:0]  pc;
   } vec_t;

   vec_t tbl[$];

   // ISA-level reference state for the random phase
   logic [7:0] m_pc, m_acc;
   logic       m_c, m_z, m_n;
   logic [7:0] m_mem [256];

   task automatic model_step(output logic [3:0] op, output logic [7:0] a);
      logic [15:0] ins;
      logic [7:0]  opnd, npc;
      int          r;
      ins  = rom[m_pc];
      op   = ins[15:12];
      a    = ins[7:0];
      opnd = ins[8] ? a : m_mem[a];
      npc  = m_pc + 8'd1;
      r    = 0;
      case (op)
         4'h1: begin m_acc = opnd; m_z = (opnd == 0); m_n = opnd[7]; end
         4'h2: m_mem[a] = m_acc;
         4'h3, 4'h5: begin
            r = int'(m_acc) + int'(opnd) + ((op == 4'h5) ? int'(m_c) : 0);
            m_c = (r > 255);
         end
         4'h4, 4'h6: begin
            r = int'(m_acc) - int'(opnd) - ((op == 4'h6) ? int'(m_c) : 0);
            m_c = (r < 0);
         end
         4'h7: begin r = int'(~(m_acc | opnd)); m_c = 1'b0; end
         4'h8: begin r = int'(~(m_acc & opnd)); m_c = 1'b0; end
         4'h9: begin r = int'(m_acc ^ opnd);    m_c = 1'b0; end
         4'hA: begin r = int'(~(m_acc ^ opnd)); m_c = 1'b0; end
         4'hB: npc = a;
         4'hC: if (m_z) npc = a;
         4'hD: if (m_c) npc = a;
         4'hE: if (m_n) npc = a;
         default: ;
      endcase
      if (op >= 4'h3 && op <= 4'hA) begin
         m_acc = 8'(r);
         m_z   = (m_acc == 8'd0);
         m_n   = m_acc[7];
      end
      m_pc = npc;
   endtask

   initial begin
      logic [3:0]  op;
      logic [7:0]  a;
      logic [15:0] w;
      reset = 1'b1;
      dif._iEnable = 1'b1;
      dif._iPData  = 16'h0000;
      dif._iDData  = 8'h00;
      for (int i = 0; i < 256; i++) begin rom[i] = 16'h0000; mem[i] = 8'h00; end

      // reset state
      tick();
      chk("reset_pc",   {24'd0, dif._oPAddr}, 32'h00);
      chk("reset_acc",  {24'd0, dif._oAcc}, 32'h00);
      chk("reset_flag", {29'd0, dif._oFlagC, dif._oFlagZ, dif._oFlagN}, 32'h0);
      chk("reset_ctl",  {29'd0, dif._oHalted, dif._oDRead, dif._oDWrite}, 32'h0);

      // directed program table: {addr, instr, acc, C, Z, N, next pc}
      tbl.push_back(vec_t'{8'h00, 16'h117F, 8'h7F, 1'b0, 1'b0, 1'b0, 8'h01});
      tbl.push_back(vec_t'{8'h01, 16'h3101, 8'h80, 1'b0, 1'b0, 1'b1, 8'h02});
      tbl.push_back(vec_t'{8'h02, 16'h3180, 8'h00, 1'b1, 1'b1, 1'b0, 8'h03});
      tbl.push_back(vec_t'{8'h03, 16'hC040, 8'h00, 1'b1, 1'b1, 1'b0, 8'h40});
      tbl.push_back(vec_t'{8'h40, 16'h11FF, 8'hFF, 1'b1, 1'b0, 1'b1, 8'h41});
      tbl.push_back(vec_t'{8'h41, 16'h5100, 8'h00, 1'b1, 1'b1, 1'b0, 8'h42});
      tbl.push_back(vec_t'{8'h42, 16'h6100, 8'hFF, 1'b1, 1'b0, 1'b1, 8'h43});
      tbl.push_back(vec_t'{8'h43, 16'h110F, 8'h0F, 1'b1, 1'b0, 1'b0, 8'h44});
      tbl.push_back(vec_t'{8'h44, 16'h7100, 8'hF0, 1'b0, 1'b0, 1'b1, 8'h45});
      tbl.push_back(vec_t'{8'h45, 16'hC080, 8'hF0, 1'b0, 1'b0, 1'b1, 8'h46});
      tbl.push_back(vec_t'{8'h46, 16'h1010, 8'h22, 1'b0, 1'b0, 1'b0, 8'h47});
      tbl.push_back(vec_t'{8'h47, 16'h2011, 8'h22, 1'b0, 1'b0, 1'b0, 8'h48});
      tbl.push_back(vec_t'{8'h48, 16'h9122, 8'h00, 1'b0, 1'b1, 1'b0, 8'h49});
      tbl.push_back(vec_t'{8'h49, 16'hE0FF, 8'h00, 1'b0, 1'b1, 1'b0, 8'h4A});
      tbl.push_back(vec_t'{8'h4A, 16'hD0FF, 8'h00, 1'b0, 1'b1, 1'b0, 8'h4B});
      tbl.push_back(vec_t'{8'h4B, 16'h8100, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h4C});
      tbl.push_back(vec_t'{8'h4C, 16'hE0FF, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hFF});
      tbl.push_back(vec_t'{8'hFF, 16'h0000, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h00});
      tbl.push_back(vec_t'{8'h00, 16'h117F, 8'h7F, 1'b0, 1'b0, 1'b0, 8'h01});
      foreach (tbl[i]) rom[tbl[i].addr] = tbl[i].instr;
      mem[8'h10] = 8'h22;
      do_reset();
      foreach (tbl[i]) begin
         chk("tbl_fetch_pc", {24'd0, dif._oPAddr}, {24'd0, tbl[i].addr});
         tick();
         chk("tbl_decode_rd", {31'd0, dif._oDRead}, {31'd0, exp_rd(tbl[i].instr)});
         tick();
         chk("tbl_exec_rd", {31'd0, dif._oDRead}, {31'd0, exp_rd(tbl[i].instr)});
         chk("tbl_exec_wr", {31'd0, dif._oDWrite}, {31'd0, tbl[i].instr[15:12] == 4'h2});
         if (exp_rd(tbl[i].instr) || tbl[i].instr[15:12] == 4'h2)
            chk("tbl_exec_daddr", {24'd0, dif._oDAddr}, {24'd0, tbl[i].instr[7:0]});
         tick();
         chk("tbl_state",
             {13'd0, dif._oAcc, dif._oFlagC, dif._oFlagZ, dif._oFlagN, dif._oPAddr},
             {13'd0, tbl[i].acc, tbl[i].c, tbl[i].z, tbl[i].n, tbl[i].pc});
      end
      chk("store_data",  {24'd0, mem[8'h11]}, 32'h22);
      chk("store_count", wr_cnt, 32'd1);
      chk("store_addr",  {24'd0, wr_addr_last}, 32'h11);

      // stall in EXECUTE of a store, then reset in the middle of DECODE
      for (int i = 0; i < 256; i++) begin rom[i] = 16'h0000; mem[i] = 8'h00; end
      rom[0] = 16'h115A; rom[1] = 16'h2030; rom[2] = 16'h1030;
      do_reset();
      repeat (5) tick();
      dif._iEnable = 1'b0;
      #1;
      chk("stall_wr0", {31'd0, dif._oDWrite}, 32'd0);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("stall_wr",  {31'd0, dif._oDWrite}, 32'd0);
         chk("stall_pc",  {24'd0, dif._oPAddr}, 32'h01);
         chk("stall_acc", {24'd0, dif._oAcc}, 32'h5A);
         chk("stall_mem", {24'd0, mem[8'h30]}, 32'h00);
      end
      dif._iEnable = 1'b1;
      #1;
      chk("unstall_wr",    {31'd0, dif._oDWrite}, 32'd1);
      chk("unstall_daddr", {24'd0, dif._oDAddr}, 32'h30);
      tick();
      chk("unstall_mem", {24'd0, mem[8'h30]}, 32'h5A);
      chk("unstall_cnt", wr_cnt, 32'd1);
      chk("unstall_pc",  {24'd0, dif._oPAddr}, 32'h02);
      tick();
      chk("mid_decode_rd", {31'd0, dif._oDRead}, 32'd1);
      reset = 1'b1;
      #1;
      chk("async_pc",   {24'd0, dif._oPAddr}, 32'h00);
      chk("async_acc",  {24'd0, dif._oAcc}, 32'h00);
      chk("async_flag", {29'd0, dif._oFlagC, dif._oFlagZ, dif._oFlagN}, 32'h0);
      chk("async_ctl",  {29'd0, dif._oHalted, dif._oDRead, dif._oDWrite}, 32'h0);
      tick();
      reset = 1'b0;
      repeat (3) tick();
      chk("restart_state", {24'd0, dif._oAcc, dif._oPAddr}, {24'd0, 8'h5A, 8'h01});

      // JMP out of 0xFF back to 0x00, then HALT
      rom[0] = 16'hB0FF; rom[8'hFF] = 16'hB000;
      do_reset();
      repeat (3) tick();
      chk("jmp_to_ff", {24'd0, dif._oPAddr}, 32'hFF);
      repeat (3) tick();
      chk("jmp_ff_to_0", {24'd0, dif._oPAddr}, 32'h00);
      rom[0] = 16'hF000;
      tick();
      tick();
      chk("halted", {31'd0, dif._oHalted}, 32'd1);
      wr_cnt = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         chk("halt_hold", {21'd0, dif._oHalted, dif._oDRead, dif._oDWrite, dif._oPAddr},
             {21'd0, 1'b1, 1'b0, 1'b0, 8'h00});
      end
      chk("halt_no_writes", wr_cnt, 32'd0);
      reset = 1'b1;
      #1;
      chk("halt_cleared", {31'd0, dif._oHalted}, 32'd0);
      tick();

      // random programs with random stalls against the ISA model
      for (int i = 0; i < 256; i++) begin
         w = 16'($urandom);
         w[15:12] = 4'($urandom_range(0, 14));
         rom[i] = w;
         mem[i] = 8'($urandom);
         m_mem[i] = mem[i];
      end
      m_pc = 8'h00; m_acc = 8'h00; m_c = 1'b0; m_z = 1'b0; m_n = 1'b0;
      do_reset();
      for (int i = 0; i < 300; i++) begin
         for (int ph = 0; ph < 3; ph++) begin
            dif._iEnable = 1'b0;
            repeat ($urandom_range(0, 3) == 0 ? 2 : 0) tick();
            dif._iEnable = 1'b1;
            tick();
         end
         model_step(op, a);
         chk("rnd_state",
             {13'd0, dif._oAcc, dif._oFlagC, dif._oFlagZ, dif._oFlagN, dif._oPAddr},
             {13'd0, m_acc, m_c, m_z, m_n, m_pc});
         if (op == 4'h2) chk("rnd_store", {24'd0, mem[a]}, {24'd0, m_mem[a]});
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
